// File: rtl/fir_stream_bridge_if.sv
// Stream and Wishbone-master signal bundle for fir_stream_bridge.
// master: the bridge's view (drives s_ready_o, m_*_o and wbm_*_o).
// slave:  the environment's view (the sample source, the result sink and the FIR bus slave).
interface fir_stream_bridge_if;
  logic        s_valid_i;
  logic [31:0] s_data_i;
  logic        s_ready_o;
  logic        m_valid_o;
  logic [31:0] m_data_o;
  logic        m_ready_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  s_valid_i, s_data_i, m_ready_i, wbm_dat_i, wbm_ack_i,
    output s_ready_o, m_valid_o, m_data_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output s_valid_i, s_data_i, m_ready_i, wbm_dat_i, wbm_ack_i,
    input  s_ready_o, m_valid_o, m_data_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/fir_stream_bridge.sv
// fir_stream_bridge: moves samples from a valid/ready stream into a Wishbone FIR
// peripheral and, on its interrupt, reads the status/result registers back out
// onto a second valid/ready stream. Bus cycles are classic single transfers with
// an ack timeout that sets a sticky error flag.
// Optional feature: define FIR_BRIDGE_SKID_EN for a two-entry input FIFO so
// samples keep flowing while a bus cycle is in progress.
module fir_stream_bridge #(
  parameter logic [31:0] DIN_ADDR    = 32'h3000_0010,
  parameter logic [31:0] STATUS_ADDR = 32'h3000_0008,
  parameter logic [31:0] DOUT_ADDR   = 32'h3000_0014,
  parameter int          OUT_RDY_BIT = 1,
  parameter int          TIMEOUT     = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                irq_i,
  output logic                err_o,
  fir_stream_bridge_if.master bus
);

  localparam int          DATA_W  = 32;
  // Last counter value before the timeout fires: cyc stays high TIMEOUT cycles.
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WR_DIN, RD_STAT, RD_DOUT, EMIT} state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                rdy_q, rdy_d;
  logic                b0_vld_q, b0_vld_d;
  logic [DATA_W-1:0]   b0_dat_q, b0_dat_d;
`ifdef FIR_BRIDGE_SKID_EN
  logic                b1_vld_q, b1_vld_d;
  logic [DATA_W-1:0]   b1_dat_q, b1_dat_d;
`endif

  logic push;
  logic pop;
  logic ack_s;
  logic tmo;

  assign push  = bus.s_valid_i && rdy_q;
  // An ack is only meaningful while a cycle is actually on the bus.
  assign ack_s = cyc_q && bus.wbm_ack_i;
  assign tmo   = cyc_q && !bus.wbm_ack_i && (cnt_q == TO_LAST);

  // Input buffer: head entry b0 is the sample being written to the FIR.
  always_comb begin
    b0_vld_d = b0_vld_q;
    b0_dat_d = b0_dat_q;
`ifdef FIR_BRIDGE_SKID_EN
    b1_vld_d = b1_vld_q;
    b1_dat_d = b1_dat_q;
    if (pop) begin
      b0_vld_d = b1_vld_q;
      b0_dat_d = b1_dat_q;
      b1_vld_d = 1'b0;
    end
    if (push) begin
      if (!b0_vld_d) begin
        b0_vld_d = 1'b1;
        b0_dat_d = bus.s_data_i;
      end else begin
        b1_vld_d = 1'b1;
        b1_dat_d = bus.s_data_i;
      end
    end
    rdy_d = !(b0_vld_d && b1_vld_d);
`else
    if (pop) b0_vld_d = 1'b0;
    if (push) begin
      b0_vld_d = 1'b1;
      b0_dat_d = bus.s_data_i;
    end
    rdy_d = !b0_vld_d;
`endif
  end

  // Next-state logic, result capture and sticky timeout error.
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // Interrupt service wins over a pending sample; a sample arriving this
        // cycle counts as present so the write starts without an extra cycle.
        if (irq_i && !m_valid_q)      state_d = RD_STAT;
        else if (b0_vld_q || push)    state_d = WR_DIN;
      end
      WR_DIN: begin
        if (ack_s || tmo) begin
          pop     = 1'b1;
          state_d = IDLE;
          if (tmo) err_d = 1'b1;
        end
      end
      RD_STAT: begin
        if (ack_s) begin
          state_d = bus.wbm_dat_i[OUT_RDY_BIT] ? RD_DOUT : IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_DOUT: begin
        if (ack_s) begin
          m_data_d  = bus.wbm_dat_i;
          m_valid_d = 1'b1;
          state_d   = EMIT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (bus.m_ready_i) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request: raised only once a bus state has been held for a cycle, so cyc
  // starts the cycle after entry and every transfer is followed by an idle cycle.
  always_comb begin
    cyc_d = 1'b0;
    we_d  = 1'b0;
    sel_d = 4'h0;
    adr_d = '0;
    dat_d = '0;
    if (state_d != state_q) cnt_d = 8'd0;
    else if (cyc_q)         cnt_d = cnt_q + 8'd1;
    else                    cnt_d = cnt_q;
    if (state_d == state_q) begin
      case (state_q)
        WR_DIN: begin
          cyc_d = 1'b1;
          we_d  = 1'b1;
          sel_d = 4'hF;
          adr_d = DIN_ADDR;
          dat_d = b0_dat_q;
        end
        RD_STAT: begin
          cyc_d = 1'b1;
          sel_d = 4'hF;
          adr_d = STATUS_ADDR;
        end
        RD_DOUT: begin
          cyc_d = 1'b1;
          sel_d = 4'hF;
          adr_d = DOUT_ADDR;
        end
        default: cyc_d = 1'b0;
      endcase
    end
  end

  // FSM, bus request and output stream registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      rdy_q     <= rdy_d;
    end
  end

  // Input buffer registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      b0_vld_q <= 1'b0;
      b0_dat_q <= '0;
`ifdef FIR_BRIDGE_SKID_EN
      b1_vld_q <= 1'b0;
      b1_dat_q <= '0;
`endif
    end else begin
      b0_vld_q <= b0_vld_d;
      b0_dat_q <= b0_dat_d;
`ifdef FIR_BRIDGE_SKID_EN
      b1_vld_q <= b1_vld_d;
      b1_dat_q <= b1_dat_d;
`endif
    end
  end

  assign bus.s_ready_o = rdy_q;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_data_o  = m_data_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign err_o         = err_q;

endmodule

// File: doc/fir_stream_bridge.md
FIR_STREAM_BRIDGE -- requirements
Module: fir_stream_bridge

Interface
REQ-001 Parameter DIN_ADDR, default 32'h3000_0010: Wishbone address of the FIR sample-input register.
REQ-002 Parameter STATUS_ADDR, default 32'h3000_0008: address of the FIR status register.
REQ-003 Parameter DOUT_ADDR, default 32'h3000_0014: address of the FIR result register.
REQ-004 Parameter OUT_RDY_BIT, default 1: status bit index meaning "result available".
REQ-005 Parameter TIMEOUT, default 255: max cycles to wait for ack (8-bit counter).
REQ-006 Clocking/reset: one clock; reset asynchronous, active-high.
REQ-007 wb_clk_i  in  1  sole clock, all state on rising edge.
REQ-008 wb_rst_i  in  1  asynchronous active-high reset.
REQ-009 s_valid_i in 1 / s_data_i in 32 / s_ready_o out 1: sample input stream; transfer when valid&ready.
REQ-010 m_valid_o out 1 / m_data_o out 32 / m_ready_i in 1: filtered-result output stream.
REQ-011 wbm_cyc_o, wbm_stb_o, wbm_we_o out 1 each; wbm_sel_o out 4; wbm_adr_o, wbm_dat_o out 32: Wishbone master request.
REQ-012 wbm_dat_i in 32, wbm_ack_i in 1: Wishbone master response.
REQ-013 irq_i in 1: FIR interrupt (level); err_o out 1: sticky bus-timeout flag.

Function
REQ-014 FSM states IDLE, WR_DIN, RD_STAT, RD_DOUT, EMIT; exactly one active.
REQ-015 IDLE priority: irq_i=1 and m_valid_o=0 -> RD_STAT; else buffered sample present -> WR_DIN; else stay.
REQ-016 WR_DIN: cyc=stb=we=1, sel=4'hF, adr=DIN_ADDR, dat=buffered sample; on ack -> IDLE, buffer freed.
REQ-017 RD_STAT: cyc=stb=1, we=0, sel=4'hF, adr=STATUS_ADDR; on ack, wbm_dat_i[OUT_RDY_BIT]=1 -> RD_DOUT, else -> IDLE.
REQ-018 RD_DOUT: read at DOUT_ADDR; on ack capture wbm_dat_i into m_data_o, set m_valid_o, -> EMIT.
REQ-019 EMIT: hold m_valid_o/m_data_o stable until m_ready_i=1; then clear m_valid_o, -> IDLE.
REQ-020 Bus cycles classic single: cyc/stb rise the cycle after state entry, drop the cycle after ack is sampled; never two back-to-back without one idle cycle.
REQ-021 wbm_dat_o = 0 and wbm_we_o = 0 whenever not in WR_DIN.
REQ-022 Timeout: ack counter clears on state entry; reaching TIMEOUT without ack drops cyc/stb, sets err_o, -> IDLE; a WR_DIN sample is discarded.
REQ-023 err_o cleared only by reset.
REQ-024 ack arriving while cyc=0 ignored.
REQ-025 Sample latency: sample accepted at edge N with FSM idle and irq_i=0 -> wbm_stb_o high after edge N+1.

Reset
REQ-026 Asserting wb_rst_i (any time, mid-cycle included): FSM -> IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, m_valid_o=0, m_data_o=0, s_ready_o=0, err_o=0, buffer empty, counter 0.
REQ-027 First edge after reset release: s_ready_o=1.

Configuration
REQ-028 Macro FIR_BRIDGE_SKID_EN: when defined, a second input register; s_ready_o = not both registers full, so input accepted during any bus state; order preserved FIFO-fashion.
REQ-029 FIR_BRIDGE_SKID_EN undefined: single register; s_ready_o=1 only when register empty.

Verification
REQ-030 Sample 32'h0000_1234 on stream, ack after 2 cycles -> one write, adr 32'h3000_0010, dat 32'h0000_1234, sel 4'hF; s_ready_o back to 1.
REQ-031 irq_i=1, status 32'h2, result 32'hDEAD_BEEF, m_ready_i=0 for 5 cycles -> m_valid_o held, m_data_o=32'hDEAD_BEEF, clears the cycle after m_ready_i=1.
REQ-032 irq_i=1, status 32'h0 -> one status read, no DOUT read, m_valid_o stays 0.
REQ-033 Write with no ack -> cyc drops after 255 cycles, err_o=1 until reset, next sample still written.
REQ-034 Sample pending and irq_i rise together in IDLE -> status read issued before sample write.
REQ-035 wb_rst_i asserted mid RD_DOUT -> cyc/stb/m_valid_o 0 asynchronously; with FIR_BRIDGE_SKID_EN, three back-to-back samples -> third stalls, order 1,2,3 on bus.
